// File: rtl/decode_stage_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decode_stage_pipe_pkg                                  |
// | Description : Shared encodings for the MIPS decode stage: next-PC    |
// |               select, branch condition codes, default reset PC.     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package decode_stage_pipe_pkg;

  // Next-PC source select
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  // Branch condition codes; 110/111 are reserved and never taken
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LEZ = 3'b010;
  localparam logic [2:0] BR_GTZ = 3'b011;
  localparam logic [2:0] BR_LTZ = 3'b100;
  localparam logic [2:0] BR_GEZ = 3'b101;

  // Boot address loaded into the IF/ID PC on reset
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

endpackage
`default_nettype wire

// File: rtl/grf_bypass.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : grf_bypass                                             |
// | Description : NREG x XLEN register file, two combinational read      |
// |               ports, one write port with write-first bypass.         |
// |               Register 0 is hard-wired to zero.                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module grf_bypass #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            w_wr_en;

  // Writes to register 0 are discarded so it can never hold a non-zero value
  assign w_wr_en = we && (waddr != '0);

  // Next-state of the storage array: one entry updated per cycle
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (w_wr_en) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage flops, cleared on reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Write-first: a same-cycle write to the read address is returned directly
  assign rdata1 = (raddr1 == '0)                    ? '0    :
                  (w_wr_en && (waddr == raddr1))    ? wdata :
                                                      regs_q[raddr1];
  assign rdata2 = (raddr2 == '0)                    ? '0    :
                  (w_wr_en && (waddr == raddr2))    ? wdata :
                                                      regs_q[raddr2];

endmodule
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : decode_stage_pipe                                      |
// | Description : MIPS decode stage: IF/ID register, register file,      |
// |               immediate extend, tag-compare forwarding, load-use     |
// |               stall detection, branch compare and next-PC select.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter  int          XLEN     = 32,
  parameter  int          NREG     = 32,
  parameter  int          NFWD     = 2,
  parameter  logic [31:0] RESET_PC = RESET_PC_DEF,
  localparam int          AW       = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr_f,
  input  logic [31:0]          pc_f,
  input  logic                 stall_d,
  input  logic                 flush_d,
  output logic [31:0]          instr_d,
  output logic [31:0]          pc_d,
  output logic                 valid_d,
  input  logic                 use_rs,
  input  logic                 use_rt,
  input  logic                 ext_op,
  input  logic [1:0]           npc_op,
  input  logic [2:0]           br_cond,
  input  logic                 we_w,
  input  logic [AW-1:0]        a3_w,
  input  logic [XLEN-1:0]      wd_w,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_ready,
  output logic [XLEN-1:0]      rd1_d,
  output logic [XLEN-1:0]      rd2_d,
  output logic [XLEN-1:0]      imm32_d,
  output logic                 br_taken,
  output logic [31:0]          next_pc,
  output logic                 stall_req
);

  // ---------------------------------------------------------------- IF/ID
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q,    ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;

  // Stall outranks flush so a stalled instruction is never lost to a bubble
  always_comb begin
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    if (stall_d) begin
      ifid_instr_d = ifid_instr_q;
    end else if (flush_d) begin
      ifid_instr_d = '0;
      ifid_pc_d    = pc_f;
      ifid_valid_d = 1'b0;
    end else begin
      ifid_instr_d = instr_f;
      ifid_pc_d    = pc_f;
      ifid_valid_d = 1'b1;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_instr_q <= '0;
      ifid_pc_q    <= RESET_PC;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign instr_d = ifid_instr_q;
  assign pc_d    = ifid_pc_q;
  assign valid_d = ifid_valid_q;

  // ------------------------------------------------------- register file
  logic [AW-1:0]   w_rs, w_rt;
  logic [XLEN-1:0] w_rf_rd1, w_rf_rd2;

  assign w_rs = ifid_instr_q[21 +: AW];
  assign w_rt = ifid_instr_q[16 +: AW];

  grf_bypass #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_grf (
    .clk    (clk),
    .reset  (reset),
    .we     (we_w),
    .waddr  (a3_w),
    .wdata  (wd_w),
    .raddr1 (w_rs),
    .raddr2 (w_rt),
    .rdata1 (w_rf_rd1),
    .rdata2 (w_rf_rd2)
  );

  // ----------------------------------------------------------- forwarding
  logic w_rs_hit, w_rt_hit, w_rs_pending, w_rt_pending;

  // Youngest matching source wins even when it is not ready yet
  always_comb begin
    rd1_d        = w_rf_rd1;
    rd2_d        = w_rf_rd2;
    w_rs_hit     = 1'b0;
    w_rt_hit     = 1'b0;
    w_rs_pending = 1'b0;
    w_rt_pending = 1'b0;
    for (int i = 0; i < NFWD; i++) begin
      if (!w_rs_hit && (w_rs != '0) && (fwd_addr[i*AW +: AW] == w_rs)) begin
        w_rs_hit = 1'b1;
        if (fwd_ready[i]) begin
          rd1_d = fwd_data[i*XLEN +: XLEN];
        end else begin
          w_rs_pending = 1'b1;
        end
      end
      if (!w_rt_hit && (w_rt != '0) && (fwd_addr[i*AW +: AW] == w_rt)) begin
        w_rt_hit = 1'b1;
        if (fwd_ready[i]) begin
          rd2_d = fwd_data[i*XLEN +: XLEN];
        end else begin
          w_rt_pending = 1'b1;
        end
      end
    end
  end

  // Bubbles never request a stall; valid is cleared by reset
  assign stall_req = ifid_valid_q &
                     ((use_rs & w_rs_pending) | (use_rt & w_rt_pending));

  // ------------------------------------------------------------ immediate
  assign imm32_d = ext_op ? {{(XLEN-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]}
                          : {{(XLEN-16){1'b0}},             ifid_instr_q[15:0]};

  // -------------------------------------------------------------- compare
  logic w_rd1_neg, w_rd1_zero;

  assign w_rd1_neg  = rd1_d[XLEN-1];
  assign w_rd1_zero = (rd1_d == '0);

  // Signed compare against zero reduces to sign bit and zero detect
  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      BR_EQ:   br_taken = (rd1_d == rd2_d);
      BR_NE:   br_taken = (rd1_d != rd2_d);
      BR_LEZ:  br_taken = w_rd1_neg | w_rd1_zero;
      BR_GTZ:  br_taken = ~w_rd1_neg & ~w_rd1_zero;
      BR_LTZ:  br_taken = w_rd1_neg;
      BR_GEZ:  br_taken = ~w_rd1_neg;
      default: br_taken = 1'b0;
    endcase
  end

  // -------------------------------------------------------------- next PC
  logic [31:0] w_pc_seq, w_br_off;

  assign w_pc_seq = pc_f + 32'd4;
  assign w_br_off = {{14{ifid_instr_q[15]}}, ifid_instr_q[15:0], 2'b00};

  // Redirects only from a valid, non-stalled decode instruction
  always_comb begin
    next_pc = w_pc_seq;
    case (npc_op)
      NPC_SEQ: next_pc = w_pc_seq;
      NPC_BR:  next_pc = br_taken ? (ifid_pc_q + 32'd4 + w_br_off) : w_pc_seq;
      NPC_J:   next_pc = {ifid_pc_q[31:28], ifid_instr_q[25:0], 2'b00};
      NPC_JR:  next_pc = rd1_d[31:0];
      default: next_pc = w_pc_seq;
    endcase
    if (stall_req || !ifid_valid_q) begin
      next_pc = w_pc_seq;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_decode_stage_pipe                                   |
// | Description : Self-checking bench for decode_stage_pipe using an     |
// |               expected-value queue.                                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_decode_stage_pipe;

  localparam int XLEN = 32;
  localparam int NFWD = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [31:0]          instr_f, pc_f;
  logic                 stall_d, flush_d;
  logic [31:0]          instr_d, pc_d;
  logic                 valid_d;
  logic                 use_rs, use_rt, ext_op;
  logic [1:0]           npc_op;
  logic [2:0]           br_cond;
  logic                 we_w;
  logic [AW-1:0]        a3_w;
  logic [XLEN-1:0]      wd_w;
  logic [NFWD*AW-1:0]   fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [NFWD-1:0]      fwd_ready;
  logic [XLEN-1:0]      rd1_d, rd2_d, imm32_d;
  logic                 br_taken;
  logic [31:0]          next_pc;
  logic                 stall_req;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  decode_stage_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .instr_f   (instr_f),
    .pc_f      (pc_f),
    .stall_d   (stall_d),
    .flush_d   (flush_d),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .valid_d   (valid_d),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .ext_op    (ext_op),
    .npc_op    (npc_op),
    .br_cond   (br_cond),
    .we_w      (we_w),
    .a3_w      (a3_w),
    .wd_w      (wd_w),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .fwd_ready (fwd_ready),
    .rd1_d     (rd1_d),
    .rd2_d     (rd2_d),
    .imm32_d   (imm32_d),
    .br_taken  (br_taken),
    .next_pc   (next_pc),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  // Drive just after the active edge; sample one time unit later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    exp_q.push_back(32'h0000_3000);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    settle();
    vectors++; e = exp_q.pop_front();
    if (pc_d !== e) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc_d, e); end
    vectors++; e = exp_q.pop_front();
    if (32'(valid_d) !== e) begin miscompares++; $display("FAIL reset_valid: got %h want %h", valid_d, e); end
    vectors++; e = exp_q.pop_front();
    if (instr_d !== e) begin miscompares++; $display("FAIL reset_instr: got %h want %h", instr_d, e); end
  endtask

  task automatic test_load;
    reset   = 1'b0;
    instr_f = 32'h1022_0003;
    pc_f    = 32'h0000_3000;
    ext_op  = 1'b1;
    npc_op  = 2'b00;
    exp_q.push_back(32'h1022_0003);
    exp_q.push_back(32'h0000_3000);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'h0000_3004);
    tick();
    vectors++; e = exp_q.pop_front();
    if (instr_d !== e) begin miscompares++; $display("FAIL load_instr: got %h want %h", instr_d, e); end
    vectors++; e = exp_q.pop_front();
    if (pc_d !== e) begin miscompares++; $display("FAIL load_pc: got %h want %h", pc_d, e); end
    vectors++; e = exp_q.pop_front();
    if (32'(valid_d) !== e) begin miscompares++; $display("FAIL load_valid: got %h want %h", valid_d, e); end
    vectors++; e = exp_q.pop_front();
    if (imm32_d !== e) begin miscompares++; $display("FAIL load_imm: got %h want %h", imm32_d, e); end
    vectors++; e = exp_q.pop_front();
    if (next_pc !== e) begin miscompares++; $display("FAIL seq_npc: got %h want %h", next_pc, e); end
  endtask

  task automatic test_rf_bypass;
    // instr_d holds rs=1, rt=2
    we_w = 1'b1; a3_w = 5'd1; wd_w = 32'd5;
    tick();
    we_w = 1'b0;
    exp_q.push_back(32'd5);
    settle();
    vectors++; e = exp_q.pop_front();
    if (rd1_d !== e) begin miscompares++; $display("FAIL rf_stored: got %h want %h", rd1_d, e); end
    we_w = 1'b1; a3_w = 5'd1; wd_w = 32'd7;
    exp_q.push_back(32'd7);
    settle();
    vectors++; e = exp_q.pop_front();
    if (rd1_d !== e) begin miscompares++; $display("FAIL rf_bypass: got %h want %h", rd1_d, e); end
    tick();
    a3_w = 5'd2; wd_w = 32'd8;
    tick();
    we_w = 1'b0;
    exp_q.push_back(32'd8);
    settle();
    vectors++; e = exp_q.pop_front();
    if (rd2_d !== e) begin miscompares++; $display("FAIL rf_rt_read: got %h want %h", rd2_d, e); end
    // rs = rt = 0
    instr_f = 32'h1000_0000; pc_f = 32'h0000_3004;
    tick();
    we_w = 1'b1; a3_w = 5'd0; wd_w = 32'd9;
    exp_q.push_back(32'd0);
    settle();
    vectors++; e = exp_q.pop_front();
    if (rd1_d !== e) begin miscompares++; $display("FAIL r0_bypass: got %h want %h", rd1_d, e); end
    tick();
    we_w = 1'b0;
    exp_q.push_back(32'd0);
    settle();
    vectors++; e = exp_q.pop_front();
    if (rd1_d !== e) begin miscompares++; $display("FAIL r0_stored: got %h want %h", rd1_d, e); end
  endtask

  task automatic test_forwarding;
    // rs=2, rt=0
    instr_f = 32'h1040_0003; pc_f = 32'h0000_3008;
    tick();
    use_rs = 1'b1; npc_op = 2'b01; br_cond = 3'b000;
    fwd_addr  = {5'd2, 5'd2};
    fwd_data  = {32'd3, 32'd0};
    fwd_ready = 2'b10;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h0000_300C);
    settle();
    vectors++; e = exp_q.pop_front();
    if (32'(stall_req) !== e) begin miscompares++; $display("FAIL fwd_shadow_stall: got %h want %h", stall_req, e); end
    vectors++; e = exp_q.pop_front();
    if (next_pc !== e) begin miscompares++; $display("FAIL fwd_stall_npc: got %h want %h", next_pc, e); end
    fwd_ready = 2'b11;
    fwd_data  = {32'd3, 32'd4};
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd0);
    settle();
    vectors++; e = exp_q.pop_front();
    if (rd1_d !== e) begin miscompares++; $display("FAIL fwd_young: got %h want %h", rd1_d, e); end
    vectors++; e = exp_q.pop_front();
    if (32'(stall_req) !== e) begin miscompares++; $display("FAIL fwd_ready_stall: got %h want %h", stall_req, e); end
    fwd_addr  = {5'd2, 5'd0};
    fwd_ready = 2'b10;
    exp_q.push_back(32'd3);
    settle();
    vectors++; e = exp_q.pop_front();
    if (rd1_d !== e) begin miscompares++; $display("FAIL fwd_old: got %h want %h", rd1_d, e); end
    // register 0 is never forwarded, even on a tag-0 not-ready source
    use_rs = 1'b0; use_rt = 1'b1;
    fwd_addr  = {5'd0, 5'd0};
    fwd_ready = 2'b00;
    fwd_data  = {32'hAAAA_AAAA, 32'h5555_5555};
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    settle();
    vectors++; e = exp_q.pop_front();
    if (32'(stall_req) !== e) begin miscompares++; $display("FAIL fwd_r0_stall: got %h want %h", stall_req, e); end
    vectors++; e = exp_q.pop_front();
    if (rd2_d !== e) begin miscompares++; $display("FAIL fwd_r0_data: got %h want %h", rd2_d, e); end
    use_rt = 1'b0;
    fwd_data = '0;
  endtask

  task automatic test_branch;
    we_w = 1'b1; a3_w = 5'd1; wd_w = 32'd8;
    tick();
    we_w = 1'b0;
    instr_f = 32'h1022_FFFF; pc_f = 32'h0000_3004;
    tick();
    npc_op = 2'b01; br_cond = 3'b000; ext_op = 1'b1;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'h0000_3004);
    exp_q.push_back(32'hFFFF_FFFF);
    settle();
    vectors++; e = exp_q.pop_front();
    if (32'(br_taken) !== e) begin miscompares++; $display("FAIL beq_taken: got %h want %h", br_taken, e); end
    vectors++; e = exp_q.pop_front();
    if (next_pc !== e) begin miscompares++; $display("FAIL beq_npc: got %h want %h", next_pc, e); end
    vectors++; e = exp_q.pop_front();
    if (imm32_d !== e) begin miscompares++; $display("FAIL imm_sext: got %h want %h", imm32_d, e); end
    br_cond = 3'b001; ext_op = 1'b0;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h0000_3008);
    exp_q.push_back(32'h0000_FFFF);
    settle();
    vectors++; e = exp_q.pop_front();
    if (32'(br_taken) !== e) begin miscompares++; $display("FAIL bne_taken: got %h want %h", br_taken, e); end
    vectors++; e = exp_q.pop_front();
    if (next_pc !== e) begin miscompares++; $display("FAIL bne_npc: got %h want %h", next_pc, e); end
    vectors++; e = exp_q.pop_front();
    if (imm32_d !== e) begin miscompares++; $display("FAIL imm_zext: got %h want %h", imm32_d, e); end
  endtask

  task automatic test_compare_jump;
    logic [2:0]  conds [6] = '{3'b100, 3'b101, 3'b010, 3'b011, 3'b011, 3'b110};
    logic [31:0] vals  [6] = '{32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'd1, 32'd0};
    logic        takes [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    fwd_addr  = {5'd0, 5'd1};
    fwd_ready = 2'b01;
    for (int k = 0; k < 6; k++) begin
      br_cond  = conds[k];
      fwd_data = {32'd0, vals[k]};
      exp_q.push_back(32'(takes[k]));
      settle();
      vectors++; e = exp_q.pop_front();
      if (32'(br_taken) !== e) begin
        miscompares++;
        $display("FAIL cmp_%0d cond=%b rd1=%h: got %h want %h", k, conds[k], vals[k], br_taken, e);
      end
    end
    npc_op   = 2'b11;
    fwd_data = {32'd0, 32'h0000_3010};
    exp_q.push_back(32'h0000_3010);
    settle();
    vectors++; e = exp_q.pop_front();
    if (next_pc !== e) begin miscompares++; $display("FAIL jr_npc: got %h want %h", next_pc, e); end
    npc_op = 2'b10;
    exp_q.push_back(32'h008B_FFFC);
    settle();
    vectors++; e = exp_q.pop_front();
    if (next_pc !== e) begin miscompares++; $display("FAIL j_npc: got %h want %h", next_pc, e); end
  endtask

  task automatic test_stall_flush;
    instr_f = 32'hDEAD_BEEF; pc_f = 32'h0000_3100;
    stall_d = 1'b1; flush_d = 1'b1;
    exp_q.push_back(32'h1022_FFFF);
    exp_q.push_back(32'h0000_3004);
    exp_q.push_back(32'd1);
    tick();
    vectors++; e = exp_q.pop_front();
    if (instr_d !== e) begin miscompares++; $display("FAIL hold_instr: got %h want %h", instr_d, e); end
    vectors++; e = exp_q.pop_front();
    if (pc_d !== e) begin miscompares++; $display("FAIL hold_pc: got %h want %h", pc_d, e); end
    vectors++; e = exp_q.pop_front();
    if (32'(valid_d) !== e) begin miscompares++; $display("FAIL hold_valid: got %h want %h", valid_d, e); end
    stall_d = 1'b0;
    npc_op  = 2'b11;
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h0000_3100);
    exp_q.push_back(32'h0000_3104);
    tick();
    vectors++; e = exp_q.pop_front();
    if (instr_d !== e) begin miscompares++; $display("FAIL flush_instr: got %h want %h", instr_d, e); end
    vectors++; e = exp_q.pop_front();
    if (32'(valid_d) !== e) begin miscompares++; $display("FAIL flush_valid: got %h want %h", valid_d, e); end
    vectors++; e = exp_q.pop_front();
    if (pc_d !== e) begin miscompares++; $display("FAIL flush_pc: got %h want %h", pc_d, e); end
    vectors++; e = exp_q.pop_front();
    if (next_pc !== e) begin miscompares++; $display("FAIL bubble_npc: got %h want %h", next_pc, e); end
    flush_d = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    vectors++; e = exp_q.pop_front();
    if (instr_d !== e) begin miscompares++; $display("FAIL reload_instr: got %h want %h", instr_d, e); end
  endtask

  initial begin
    reset = 1'b1; instr_f = '0; pc_f = '0; stall_d = 1'b0; flush_d = 1'b0;
    use_rs = 1'b0; use_rt = 1'b0; ext_op = 1'b0; npc_op = 2'b00; br_cond = 3'b000;
    we_w = 1'b0; a3_w = '0; wd_w = '0;
    fwd_addr = '0; fwd_data = '0; fwd_ready = '0;
    test_reset();
    test_load();
    test_rf_bypass();
    test_forwarding();
    test_branch();
    test_compare_jump();
    test_stall_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
